// File: rtl/icache_nway.sv
// Set-associative instruction cache with a round-robin victim per set.
// Misses refill one whole block, one word per beat, from the memory port.
module icache_nway #(
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int WORDS = 2,
  parameter int CPUID = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(SETS);
  localparam int TB = 30 - OB - IB;
  localparam int OW = (OB > 0) ? OB : 1;
  localparam int VW = (WAYS > 1) ? $clog2(WAYS) : 1;

  if (SETS < 2 || SETS > 64 || WAYS < 1 || WAYS > 4 || WORDS < 1 || WORDS > 8 || CPUID < 0)
  begin : g_bad_params
    $error("icache_nway: parameter out of range");
  end

  typedef enum logic {IDLE, FILL} state_t;

  state_t         state_q, state_d;
  logic [OW-1:0]  cnt_q, cnt_d;
  logic [TB-1:0]  tag_q, tag_d;
  logic [IB-1:0]  idx_q, idx_d;
  logic [VW-1:0]  way_q, way_d;
  logic           valid_q [SETS][WAYS];
  logic           valid_d [SETS][WAYS];
  logic [VW-1:0]  ptr_q [SETS];
  logic [VW-1:0]  ptr_d [SETS];
  logic [TB-1:0]  tag_arr_q [SETS][WAYS];
  logic [31:0]    data_arr_q [SETS][WAYS][WORDS];

  logic [TB-1:0]  req_tag;
  logic [IB-1:0]  req_idx;
  logic [OW-1:0]  req_off;
  logic           hit_any;
  logic [VW-1:0]  hit_way;
  logic           last_word;
  logic           data_we;
  logic           tag_we;
  logic [31:0]    fill_addr;
  logic           unused_addr;

  assign unused_addr = ^imemaddr[1:0];
  assign req_tag     = imemaddr[31 -: TB];
  assign req_idx     = imemaddr[2+OB +: IB];

  if (OB > 0) begin : g_off
    assign req_off   = imemaddr[2 +: OW];
    assign fill_addr = {tag_q, idx_q, cnt_q, 2'b00};
  end else begin : g_no_off
    assign req_off   = '0;
    assign fill_addr = {tag_q, idx_q, 2'b00};
  end

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_arr_q[req_idx][w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = VW'(w);
      end
    end
  end

  assign ihit      = (state_q == IDLE) && imemREN && hit_any;
  assign imemload  = ihit ? data_arr_q[req_idx][hit_way][req_off] : 32'h0;
  assign iREN      = (state_q == FILL);
  assign iaddr     = (state_q == FILL) ? fill_addr : 32'h0;
  assign last_word = (cnt_q == OW'(WORDS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    way_d   = way_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    data_we = 1'b0;
    tag_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (imemREN && !hit_any && !iflush) begin
          tag_d   = req_tag;
          idx_d   = req_idx;
          way_d   = ptr_q[req_idx];
          cnt_d   = '0;
          // The victim goes invalid for the whole refill so a partial block never hits.
          valid_d[req_idx][ptr_q[req_idx]] = 1'b0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (!iwait) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (last_word) begin
            valid_d[idx_q][way_q] = 1'b1;
            tag_we  = 1'b1;
            ptr_d[idx_q] = (ptr_q[idx_q] == VW'(WAYS - 1)) ? '0 : ptr_q[idx_q] + VW'(1);
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush overrides everything, including a final fill beat in the same cycle.
    if (iflush) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          valid_d[s][w] = 1'b0;
      ptr_d   = ptr_q;
      data_we = 1'b0;
      tag_we  = 1'b0;
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        ptr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++)
          valid_q[s][w] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    tag_q <= tag_d;
    idx_q <= idx_d;
    way_q <= way_d;
    if (data_we)
      data_arr_q[idx_q][way_q][cnt_q] <= iload;
    if (tag_we)
      tag_arr_q[idx_q][way_q] <= tag_q;
  end

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway (default geometry: 8 sets, 2 ways, 2 words).
// Memory returns iaddr ^ 32'hC0DE_0000, so every fetched word is predictable.
module tb_icache_nway;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] KEY = 32'hC0DE_0000;

  icache_nway dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .iflush(iflush), .ihit(ihit), .imemload(imemload), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload)
  );

  assign iload = iaddr ^ KEY;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; iflush = 1'b0; iwait = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    #1;
  endtask

  // Present a fetch and count clock edges until ihit (20 means it never hit).
  task automatic fetch(input logic [31:0] a, output int cyc);
    imemREN = 1'b1; imemaddr = a;
    #1;
    cyc = 0;
    while (ihit !== 1'b1 && cyc < 20) begin
      @(posedge CLK); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; iflush = 1'b0; iwait = 1'b0;
    #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit: got %b want 0", ihit); end
    checks++; if (imemload !== 32'h0) begin errors++; $display("FAIL reset_imemload: got %h want 0", imemload); end
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL reset_iREN: got %b want 0", iREN); end
    checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr: got %h want 0", iaddr); end
    @(posedge CLK); #1;
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL reset_hold_iREN: got %b want 0", iREN); end
    nRST = 1'b1; imemREN = 1'b0;
    #1;
  endtask

  task automatic test_basic_fill();
    apply_reset();
    imemREN = 1'b1; imemaddr = 32'h40;
    #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL basic_miss: got ihit=%b want 0", ihit); end
    @(posedge CLK); #1;
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h40) begin errors++; $display("FAIL basic_beat0: got iREN=%b iaddr=%h want 1 00000040", iREN, iaddr); end
    @(posedge CLK); #1;
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h44) begin errors++; $display("FAIL basic_beat1: got iREN=%b iaddr=%h want 1 00000044", iREN, iaddr); end
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL basic_partial: got ihit=%b want 0", ihit); end
    @(posedge CLK); #1;
    checks++; if (ihit !== 1'b1 || imemload !== 32'hC0DE_0040) begin errors++; $display("FAIL basic_hit40: got ihit=%b load=%h want 1 c0de0040", ihit, imemload); end
    checks++; if (iREN !== 1'b0 || iaddr !== 32'h0) begin errors++; $display("FAIL basic_idle: got iREN=%b iaddr=%h want 0 0", iREN, iaddr); end
    imemaddr = 32'h44;
    #1;
    checks++; if (ihit !== 1'b1 || imemload !== 32'hC0DE_0044) begin errors++; $display("FAIL basic_hit44: got ihit=%b load=%h want 1 c0de0044", ihit, imemload); end
    @(posedge CLK); #1;
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL basic_no_iREN: got %b want 0", iREN); end
    imemREN = 1'b0;
  endtask

  task automatic test_eviction();
    int c;
    apply_reset();
    fetch(32'h40, c);
    checks++; if (c !== 3) begin errors++; $display("FAIL evict_fill40: got %0d cycles want 3", c); end
    fetch(32'h140, c);
    checks++; if (c !== 3) begin errors++; $display("FAIL evict_fill140: got %0d cycles want 3", c); end
    fetch(32'h240, c);
    checks++; if (c !== 3) begin errors++; $display("FAIL evict_fill240: got %0d cycles want 3", c); end
    fetch(32'h144, c);
    checks++; if (c !== 0 || imemload !== 32'hC0DE_0144) begin errors++; $display("FAIL evict_keep140: got %0d cycles load=%h want 0 c0de0144", c, imemload); end
    fetch(32'h240, c);
    checks++; if (c !== 0 || imemload !== 32'hC0DE_0240) begin errors++; $display("FAIL evict_hit240: got %0d cycles load=%h want 0 c0de0240", c, imemload); end
    fetch(32'h40, c);
    checks++; if (c !== 3) begin errors++; $display("FAIL evict_refetch40: got %0d cycles want 3", c); end
    imemREN = 1'b0;
  endtask

  task automatic test_back_to_back();
    int c;
    apply_reset();
    fetch(32'h40, c);
    for (int i = 0; i < 4; i++) begin
      imemaddr = (i % 2 == 0) ? 32'h44 : 32'h40;
      #1;
      checks++;
      if (ihit !== 1'b1 || imemload !== (imemaddr ^ KEY) || iREN !== 1'b0) begin
        errors++; $display("FAIL b2b_hit%0d: got ihit=%b load=%h iREN=%b want 1 %h 0", i, ihit, imemload, iREN, imemaddr ^ KEY);
      end
      @(posedge CLK); #1;
    end
    fetch(32'h140, c);
    checks++; if (c !== 3) begin errors++; $display("FAIL b2b_fill140: got %0d cycles want 3", c); end
    fetch(32'h40, c);
    checks++; if (c !== 0) begin errors++; $display("FAIL b2b_keep40: got %0d cycles want 0", c); end
    imemREN = 1'b0;
  endtask

  task automatic test_iwait();
    int c;
    apply_reset();
    iwait = 1'b1; imemREN = 1'b1; imemaddr = 32'h40;
    #1;
    @(posedge CLK); #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (iREN !== 1'b1 || iaddr !== 32'h40 || ihit !== 1'b0) begin
        errors++; $display("FAIL iwait_stall%0d: got iREN=%b iaddr=%h ihit=%b want 1 00000040 0", i, iREN, iaddr, ihit);
      end
      @(posedge CLK); #1;
    end
    iwait = 1'b0;
    c = 0;
    while (ihit !== 1'b1 && c < 10) begin
      @(posedge CLK); #1;
      c++;
    end
    checks++; if (c !== 2 || imemload !== 32'hC0DE_0040) begin errors++; $display("FAIL iwait_complete: got %0d cycles load=%h want 2 c0de0040", c, imemload); end
    imemREN = 1'b0;
  endtask

  task automatic test_addr_change();
    int c;
    apply_reset();
    imemREN = 1'b1; imemaddr = 32'h80;
    #1;
    @(posedge CLK); #1;
    imemaddr = 32'h100;
    #1;
    checks++; if (iaddr !== 32'h80) begin errors++; $display("FAIL chg_beat0: got %h want 00000080", iaddr); end
    @(posedge CLK); #1;
    checks++; if (iaddr !== 32'h84) begin errors++; $display("FAIL chg_beat1: got %h want 00000084", iaddr); end
    @(posedge CLK); #1;
    checks++; if (ihit !== 1'b0 || iREN !== 1'b0) begin errors++; $display("FAIL chg_miss100: got ihit=%b iREN=%b want 0 0", ihit, iREN); end
    @(posedge CLK); #1;
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h100) begin errors++; $display("FAIL chg_fill100: got iREN=%b iaddr=%h want 1 00000100", iREN, iaddr); end
    c = 0;
    while (ihit !== 1'b1 && c < 10) begin
      @(posedge CLK); #1;
      c++;
    end
    checks++; if (c !== 2) begin errors++; $display("FAIL chg_done100: got %0d cycles want 2", c); end
    imemaddr = 32'h84;
    #1;
    checks++; if (ihit !== 1'b1 || imemload !== 32'hC0DE_0084) begin errors++; $display("FAIL chg_hit84: got ihit=%b load=%h want 1 c0de0084", ihit, imemload); end
    imemREN = 1'b0;
  endtask

  task automatic test_flush();
    int c;
    logic [31:0] addrs [5];
    addrs[0] = 32'h40; addrs[1] = 32'h140; addrs[2] = 32'h48; addrs[3] = 32'h148; addrs[4] = 32'h50;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      fetch(addrs[i], c);
      checks++; if (c !== 3) begin errors++; $display("FAIL flush_prefill%0d: got %0d cycles want 3", i, c); end
    end
    imemaddr = 32'h50;
    #1;
    @(posedge CLK); #1;
    iflush = 1'b1; imemREN = 1'b0;
    #1;
    checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL flush_midfill: got iREN=%b want 1", iREN); end
    @(posedge CLK); #1;
    iflush = 1'b0;
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL flush_idle: got iREN=%b want 0", iREN); end
    for (int i = 0; i < 5; i++) begin
      imemREN = 1'b1; imemaddr = addrs[i];
      #1;
      checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL flush_miss%0d: addr %h got ihit=%b want 0", i, addrs[i], ihit); end
      imemREN = 1'b0;
    end
  endtask

  task automatic test_flush_final();
    int c;
    apply_reset();
    imemREN = 1'b1; imemaddr = 32'h40;
    #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    checks++; if (iaddr !== 32'h44) begin errors++; $display("FAIL flfin_last_beat: got %h want 00000044", iaddr); end
    iflush = 1'b1;
    @(posedge CLK); #1;
    iflush = 1'b0;
    checks++; if (ihit !== 1'b0 || iREN !== 1'b0) begin errors++; $display("FAIL flfin_invalid: got ihit=%b iREN=%b want 0 0", ihit, iREN); end
    fetch(32'h40, c);
    checks++; if (c !== 3) begin errors++; $display("FAIL flfin_refill: got %0d cycles want 3", c); end
    imemREN = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    int c;
    apply_reset();
    fetch(32'h40, c);
    checks++; if (c !== 3) begin errors++; $display("FAIL rstfill_prefill: got %0d cycles want 3", c); end
    imemaddr = 32'h140;
    #1;
    @(posedge CLK); #1;
    checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL rstfill_infill: got iREN=%b want 1", iREN); end
    nRST = 1'b0;
    #1;
    checks++; if (iREN !== 1'b0 || iaddr !== 32'h0) begin errors++; $display("FAIL rstfill_async: got iREN=%b iaddr=%h want 0 0", iREN, iaddr); end
    @(posedge CLK); #1;
    nRST = 1'b1; imemaddr = 32'h40;
    #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rstfill_miss40: got ihit=%b want 0", ihit); end
    imemaddr = 32'h140;
    #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rstfill_miss140: got ihit=%b want 0", ihit); end
    imemREN = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; iflush = 1'b0; iwait = 1'b0;
    @(posedge CLK); #1;
    test_reset();
    test_basic_fill();
    test_eviction();
    test_back_to_back();
    test_iwait();
    test_addr_change();
    test_flush();
    test_flush_final();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_nway.md
ICACHE_NWAY -- requirements
Module: icache_nway

Interface
REQ-001 SETS, default 8, number of sets; power of 2, range 2..64.
REQ-002 WAYS, default 2, associativity; power of 2, range 1..4.
REQ-003 WORDS, default 2, 32-bit words per block; power of 2, range 1..8.
REQ-004 CPUID, default 0, selects this core's slot in the arbiter-side arrays.
REQ-005 CLK  in  1  single clock; all state updates on rising edge.
REQ-006 nRST  in  1  asynchronous, active-low reset.
REQ-007 imemREN  in  1  datapath instruction fetch request.
REQ-008 imemaddr  in  32  fetch byte address; bits [1:0] ignored.
REQ-009 iflush  in  1  invalidate all lines.
REQ-010 ihit  out  1  requested word present; imemload valid this cycle.
REQ-011 imemload  out  32  instruction word for imemaddr.
REQ-012 iREN  out  1  memory read request, driven onto iREN[CPUID].
REQ-013 iaddr  out  32  memory word address, driven onto iaddr[CPUID].
REQ-014 iwait  in  1  iwait[CPUID]; low = iload valid this cycle.
REQ-015 iload  in  32  iload[CPUID]; fill data.

Function
REQ-016 Address split: [1:0] byte, next log2(WORDS) bits word offset, next log2(SETS) bits index, remaining upper bits tag.
REQ-017 Storage per set: WAYS x {valid, tag, WORDS data words}, plus a log2(WAYS)-bit round-robin victim pointer.
REQ-018 FSM states IDLE and FILL; the FSM is in IDLE after reset.
REQ-019 ihit is combinational: state==IDLE, imemREN=1, and some way in the indexed set is valid with a matching tag; otherwise 0.
REQ-020 imemload is the hitting way's word at the word offset; 0 when ihit=0.
REQ-021 In IDLE, imemREN=1 with ihit=0 and iflush=0 latches the tag, index and victim way, clears the word counter, and moves to FILL next cycle.
REQ-022 In FILL, iREN=1 and iaddr={latched tag, latched index, counter, 2'b00}; in IDLE, iREN=0 and iaddr=0.
REQ-023 In FILL, each cycle with iwait=0 writes iload into the victim way at the counter position and increments the counter; with iwait=1, nothing changes.
REQ-024 On the write of word WORDS-1, the victim way gets valid=1 and the latched tag, the set's victim pointer advances by 1 modulo WAYS, and the FSM returns to IDLE.
REQ-025 While in FILL, the victim way's valid bit is 0, so a partial line never hits.
REQ-026 A change on imemaddr or imemREN during FILL does not abort the fill; the latched line completes.
REQ-027 Zero-wait miss latency: miss detected in cycle N; fill occupies cycles N+1..N+WORDS; ihit=1 in cycle N+WORDS+1.
REQ-028 A hit never changes any valid bit, tag, data or victim pointer.
REQ-029 iflush=1 clears every valid bit on the next edge and, if in FILL, aborts to IDLE; victim pointers and data are unchanged.
REQ-030 iflush takes priority over a simultaneous final fill write; the line is left invalid.
REQ-031 With WAYS=1, the victim pointer is constant 0 and the block behaves as direct-mapped.

Reset
REQ-032 While nRST=0, and immediately on its assertion: all valid bits 0, all victim pointers 0, counter 0, state IDLE.
REQ-033 During reset, outputs read ihit=0, imemload=0, iREN=0 and iaddr=0.
REQ-034 Reset asserted mid-FILL abandons the fill; the victim line is left invalid.
REQ-035 Data arrays need no reset.

Verification
REQ-036 Defaults, iwait=0, fetch 0x40 -> iREN high 2 cycles with iaddr 0x40 then 0x44; ihit=1 the next cycle; a fetch of 0x44 then hits with no iREN.
REQ-037 Fetch 0x40, then 0x140 and 0x240 (all set 0) -> the 0x240 fill evicts way 0 (0x40); 0x140 still hits; 0x40 misses again.
REQ-038 iwait held high 5 cycles on the first fill word -> iREN and iaddr stay stable and ihit stays 0 throughout; the line completes after iwait falls.
REQ-039 imemaddr changed from 0x80 to 0x100 mid-fill -> the 0x80 line completes; the FSM then misses on 0x100.
REQ-040 iflush while 4 lines are valid and one is mid-fill -> the next cycle is IDLE; all 5 addresses miss.
REQ-041 nRST pulsed low mid-FILL -> iREN=0 immediately; the previously filled address misses after release.
